// File: rtl/operand_entry_bank.sv
// Operand entry bank: edge-detected digit buttons are queued in a pending
// mask and applied one digit per cycle (lowest digit first) to the selected
// operand register. Also holds the committed ALU result and the one before it.
module operand_entry_bank #(
  parameter int DIGITS     = 8,
  parameter int NUM_OPS    = 3,
  parameter int SEL_W      = 2,
  parameter int CARRY_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGITS-1:0]      btn_inc,
  input  logic                   dec,
  input  logic [SEL_W-1:0]       op_sel,
  input  logic                   clr,
  input  logic                   load_res,
  input  logic [8*DIGITS-1:0]    result_in,
  input  logic                   result_valid,
  output logic [NUM_OPS*4*DIGITS-1:0] ops_flat,
  output logic [8*DIGITS-1:0]    result_q,
  output logic [8*DIGITS-1:0]    last_result_q,
  output logic                   busy
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0] btn_q, btn_d;
  logic [DIGITS-1:0] pending_q, pending_d;
  logic [DIGITS-1:0] rise;
  logic [DIGITS-1:0] svc_mask;
  logic [IDX_W-1:0]  svc_idx;
  logic [IDX_W+1:0]  svc_sh;
  logic              svc_en;
  logic [2*W-1:0]    result_d, last_result_d;

  // Edge detect and select the lowest pending digit for service this cycle
  always_comb begin
    rise     = btn_inc & ~btn_q;
    btn_d    = btn_inc;
    svc_mask = pending_q & (~pending_q + DIGITS'(1));
    svc_idx  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (pending_q[i]) svc_idx = IDX_W'(i);
    end
    svc_sh = {svc_idx, 2'b00};
    // clr and load_res both pre-empt the service slot
    svc_en = (|pending_q) & ~clr & ~load_res;
  end

  // Pending queue update: clr flushes everything including this edge's rises;
  // a serviced bit is cleared but a same-edge rise on it re-arms it
  always_comb begin
    pending_d = pending_q | rise;
    if (clr) begin
      pending_d = '0;
    end else if (svc_en) begin
      pending_d = (pending_q & ~svc_mask) | rise;
    end
  end

  // Result commit; load_res reads result_q before this edge's commit
  always_comb begin
    result_d      = result_q;
    last_result_d = last_result_q;
    if (result_valid) begin
      result_d      = result_in;
      last_result_d = result_q;
    end
  end

  // Shared state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q         <= btn_inc;
      pending_q     <= '0;
      result_q      <= '0;
      last_result_q <= '0;
    end else begin
      btn_q         <= btn_d;
      pending_q     <= pending_d;
      result_q      <= result_d;
      last_result_q <= last_result_d;
    end
  end

  assign busy = |pending_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
      logic [W-1:0] op_q, op_d, step_val;
      logic [3:0]   nib;
      logic         hit;

      // Next value of this operand; only the selected one ever changes
      always_comb begin
        hit = (op_sel == SEL_W'(gi));
        nib = op_q[svc_sh +: 4];
        step_val = op_q;
        if (CARRY_MODE != 0) begin
          step_val = dec ? op_q - (W'(1) << svc_sh) : op_q + (W'(1) << svc_sh);
        end else begin
          step_val[svc_sh +: 4] = dec ? nib - 4'd1 : nib + 4'd1;
        end
        op_d = op_q;
        if (hit) begin
          if (clr) begin
            op_d = '0;
          end else if (load_res) begin
            op_d = result_q[W-1:0];
          end else if (svc_en) begin
            op_d = step_val;
          end
        end
      end

      // Operand register
      always_ff @(posedge clk) begin
        if (rst) begin
          op_q <= '0;
        end else begin
          op_q <= op_d;
        end
      end

      assign ops_flat[gi*W +: W] = op_q;
    end
  endgenerate

endmodule

// File: tb/tb_operand_entry_bank.sv
// Directed bench: two instances (wrap and carry mode) share the same stimulus.
module tb_operand_entry_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  btn_inc;
  logic        dec;
  logic [1:0]  op_sel;
  logic        clr;
  logic        load_res;
  logic [63:0] result_in;
  logic        result_valid;

  logic [95:0] ops0, ops1;
  logic [63:0] res0, res1, last0, last1;
  logic        busy0, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_entry_bank #(.CARRY_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .dec(dec), .op_sel(op_sel),
    .clr(clr), .load_res(load_res), .result_in(result_in),
    .result_valid(result_valid), .ops_flat(ops0), .result_q(res0),
    .last_result_q(last0), .busy(busy0)
  );

  operand_entry_bank #(.CARRY_MODE(1)) u_carry (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .dec(dec), .op_sel(op_sel),
    .clr(clr), .load_res(load_res), .result_in(result_in),
    .result_valid(result_valid), .ops_flat(ops1), .result_q(res1),
    .last_result_q(last1), .busy(busy1)
  );

  function automatic logic [31:0] opw(input logic [95:0] f, input int i);
    return f[i*32 +: 32];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; btn_inc = 8'h01; dec = 1'b0; op_sel = 2'd0; clr = 1'b0;
    load_res = 1'b0; result_in = '0; result_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("reset_busy", {63'd0, busy0}, 64'd0);
    check_eq("reset_res", res0, 64'd0);

    // T1: held through reset never fires
    tick(); tick(); tick();
    check_eq("t1_hold_op0_w", opw(ops0, 0), 32'h0);
    check_eq("t1_hold_busy", {62'd0, busy0, busy1}, 64'd0);
    btn_inc = 8'h00; tick();
    btn_inc = 8'h01; tick();
    check_eq("t1_press_busy", {63'd0, busy0}, 64'd1);
    check_eq("t1_press_op0_pre", opw(ops0, 0), 32'h0);
    tick();
    check_eq("t1_op0_w", opw(ops0, 0), 32'h1);
    check_eq("t1_op0_c", opw(ops1, 0), 32'h1);
    check_eq("t1_busy_done", {63'd0, busy0}, 64'd0);
    btn_inc = 8'h00; tick();

    // clear op0
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("clr_op0", opw(ops0, 0), 32'h0);

    // T2: decrement digit 0 from zero
    dec = 1'b1; btn_inc = 8'h01; tick(); btn_inc = 8'h00; tick();
    check_eq("t2_dec_w", opw(ops0, 0), 32'h0000000F);
    check_eq("t2_dec_c", opw(ops1, 0), 32'hFFFFFFFF);
    dec = 1'b0;

    // T3: op1 = 0xF via commit + load, then increment
    result_in = 64'hF; result_valid = 1'b1; tick(); result_valid = 1'b0;
    op_sel = 2'd1; load_res = 1'b1; tick(); load_res = 1'b0;
    check_eq("t3_load_op1", opw(ops1, 1), 32'hF);
    btn_inc = 8'h01; tick(); btn_inc = 8'h00; tick();
    check_eq("t3_inc_c", opw(ops1, 1), 32'h00000010);
    check_eq("t3_inc_w", opw(ops0, 1), 32'h00000000);
    check_eq("t3_op0_kept", opw(ops0, 0), 32'h0000000F);

    // T4: three simultaneous presses on op2
    op_sel = 2'd2; btn_inc = 8'h85; tick(); btn_inc = 8'h00;
    check_eq("t4_n_busy", {63'd0, busy0}, 64'd1);
    check_eq("t4_n_op2", opw(ops0, 2), 32'h0);
    tick();
    check_eq("t4_n1_op2", opw(ops0, 2), 32'h00000001);
    check_eq("t4_n1_busy", {63'd0, busy0}, 64'd1);
    tick();
    check_eq("t4_n2_op2", opw(ops0, 2), 32'h00000101);
    check_eq("t4_n2_busy", {63'd0, busy1}, 64'd1);
    tick();
    check_eq("t4_n3_op2_w", opw(ops0, 2), 32'h10000101);
    check_eq("t4_n3_op2_c", opw(ops1, 2), 32'h10000101);
    check_eq("t4_n3_busy", {63'd0, busy0}, 64'd0);

    // T5: clr flushes pending 0x05
    btn_inc = 8'h05; tick();
    btn_inc = 8'h00; clr = 1'b1; tick(); clr = 1'b0;
    check_eq("t5_clr_op2", opw(ops0, 2), 32'h0);
    check_eq("t5_clr_busy", {63'd0, busy0}, 64'd0);
    tick(); tick();
    check_eq("t5_no_update", opw(ops1, 2), 32'h0);

    // out-of-range select: pending consumed, nothing changes
    op_sel = 2'd3; btn_inc = 8'h02; tick(); btn_inc = 8'h00; tick();
    check_eq("sel3_busy", {63'd0, busy0}, 64'd0);
    check_eq("sel3_op0", opw(ops0, 0), 32'h0000000F);
    check_eq("sel3_op1", opw(ops0, 1), 32'h0);

    // T6: two commits then load into op1
    result_in = 64'h1234; result_valid = 1'b1; tick();
    result_in = 64'hABCD; tick(); result_valid = 1'b0;
    check_eq("t6_result", res0, 64'hABCD);
    check_eq("t6_last", last0, 64'h1234);
    op_sel = 2'd1; load_res = 1'b1; tick(); load_res = 1'b0;
    check_eq("t6_load_op1", opw(ops0, 1), 32'h0000ABCD);
    // same-edge commit and load: load sees pre-commit result
    op_sel = 2'd0; result_in = 64'h5555; result_valid = 1'b1; load_res = 1'b1; tick();
    result_valid = 1'b0; load_res = 1'b0;
    check_eq("t6_same_op0", opw(ops1, 0), 32'h0000ABCD);
    check_eq("t6_same_res", res1, 64'h5555);
    check_eq("t6_same_last", last1, 64'hABCD);

    // load_res defers a pending service by one cycle
    op_sel = 2'd1; btn_inc = 8'h01; tick(); btn_inc = 8'h00;
    load_res = 1'b1; tick(); load_res = 1'b0;
    check_eq("defer_load_op1", opw(ops0, 1), 32'h00005555);
    check_eq("defer_busy", {63'd0, busy0}, 64'd1);
    tick();
    check_eq("defer_svc_op1", opw(ops0, 1), 32'h00005556);
    check_eq("defer_busy_done", {63'd0, busy0}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
